// File: rtl/dmem_mmio_responder_if.sv
// Memory-stage data port between the RV32I core (master) and its data responder (slave).
// Reads are combinational: read_data_m answers data_addr_m in the same cycle.
interface dmem_mmio_responder_if;
  logic        mem_write;
  logic [31:0] data_addr_m;
  logic [31:0] write_data_m;
  logic [31:0] read_data_m;

  modport master (
    output mem_write,
    output data_addr_m,
    output write_data_m,
    input  read_data_m
  );

  modport slave (
    input  mem_write,
    input  data_addr_m,
    input  write_data_m,
    output read_data_m
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data RAM plus MMIO window (TX byte FIFO, cycle counter, tohost halt) for the RV32I core.
// No stall path exists on this port: reads are combinational, writes commit on the clock edge.
module dmem_mmio_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  dmem_mmio_responder_if.slave        bus,
  output logic                        tx_valid,
  output logic [7:0]                  tx_data,
  input  logic                        tx_ready,
  output logic                        halt,
  output logic [31:0]                 exit_code
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [FW:0] FULL_COUNT = (FW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    OFF_TXDATA = 2'd0,
    OFF_STATUS = 2'd1,
    OFF_CYCLE  = 2'd2,
    OFF_TOHOST = 2'd3
  } mmio_off_e;

  logic [31:0]   ram [DEPTH_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic [FW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [FW:0]   count_reg, count_next;
  logic          overflow_reg;
  logic [31:0]   cycle_reg;
  logic          halt_reg;
  logic [31:0]   exit_code_reg;

  logic          sel_ram, sel_mmio, wr_en;
  mmio_off_e     mmio_off;
  logic [AW-1:0] ram_idx;
  logic          ram_we, push_req, push_ok, pop, ovf_clr, cyc_load, tohost_we;
  logic          fifo_empty, fifo_full;
  logic [4:0]    count_wide;
  logic [31:0]   status_word;
  logic          unused_bits;

  // Decode
  assign sel_ram  = (bus.data_addr_m[31:28] == 4'h0);
  assign sel_mmio = (bus.data_addr_m[31:4] == MMIO_BASE[31:4]);
  assign mmio_off = mmio_off_e'(bus.data_addr_m[3:2]);
  assign ram_idx  = bus.data_addr_m[AW+1:2];

  // A halted core may keep issuing stores; none of them may change state.
  assign wr_en     = bus.mem_write && !halt_reg;
  assign ram_we    = wr_en && sel_ram;
  assign push_req  = wr_en && sel_mmio && (mmio_off == OFF_TXDATA);
  assign ovf_clr   = wr_en && sel_mmio && (mmio_off == OFF_STATUS) && bus.write_data_m[2];
  assign cyc_load  = wr_en && sel_mmio && (mmio_off == OFF_CYCLE);
  assign tohost_we = wr_en && sel_mmio && (mmio_off == OFF_TOHOST);

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_COUNT);
  assign push_ok    = push_req && !fifo_full;
  assign pop        = !fifo_empty && tx_ready;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= bus.write_data_m;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= bus.write_data_m[7:0];
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + (FW+1)'(1);
      2'b01:   count_next = count_reg - (FW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers are power-of-two wide, so they wrap at FIFO_DEPTH on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + FW'(1);
      end
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + FW'(1);
      end
      if (push_req && fifo_full) begin
        overflow_reg <= 1'b1;
      end else if (ovf_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_reg     <= 32'd0;
      halt_reg      <= 1'b0;
      exit_code_reg <= 32'd0;
    end else begin
      if (cyc_load) begin
        cycle_reg <= bus.write_data_m;
      end else if (!halt_reg) begin
        cycle_reg <= cycle_reg + 32'd1;
      end
      if (tohost_we) begin
        halt_reg      <= 1'b1;
        exit_code_reg <= bus.write_data_m;
      end
    end
  end

  // Count field is 4 bits wide; a full 16-entry FIFO reads back as 0 with full set.
  assign count_wide  = 5'(count_reg);
  assign status_word = {20'd0, count_wide[3:0], 5'd0, overflow_reg, fifo_full, fifo_empty};

  always_comb begin
    bus.read_data_m = 32'd0;
    if (sel_ram) begin
      bus.read_data_m = ram[ram_idx];
    end else if (sel_mmio) begin
      case (mmio_off)
        OFF_TXDATA: bus.read_data_m = 32'd0;
        OFF_STATUS: bus.read_data_m = status_word;
        OFF_CYCLE:  bus.read_data_m = cycle_reg;
        OFF_TOHOST: bus.read_data_m = exit_code_reg;
        default:    bus.read_data_m = 32'd0;
      endcase
    end
  end

  assign tx_valid  = !fifo_empty;
  assign tx_data   = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_reg];
  assign halt      = halt_reg;
  assign exit_code = exit_code_reg;

  assign unused_bits = &{1'b0, bus.data_addr_m[1:0], count_wide[4]};

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue/array model.
module tb_dmem_mmio_responder;

  localparam logic [31:0] A_TX  = 32'h1000_0000;
  localparam logic [31:0] A_ST  = 32'h1000_0004;
  localparam logic [31:0] A_CYC = 32'h1000_0008;
  localparam logic [31:0] A_TH  = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_valid, tx_ready, halt;
  logic [7:0]  tx_data;
  logic [31:0] exit_code;

  always #5 clk = ~clk;

  dmem_mmio_responder_if bus();

  dmem_mmio_responder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .halt      (halt),
    .exit_code (exit_code)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [31:0] m_ram    [1024];
  bit          m_ram_ok [1024];
  logic [7:0]  m_q[$];
  bit          m_ovf, m_halt;
  logic [31:0] m_cyc, m_exit;

  function automatic void m_reset();
    m_q.delete();
    m_ovf  = 0;
    m_halt = 0;
    m_cyc  = 0;
    m_exit = 0;
    for (int i = 0; i < 1024; i++) m_ram_ok[i] = 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
    int idx;
    int cnt;
    known = 1;
    cnt = m_q.size();
    if (a < 32'h1000_0000) begin
      idx   = int'((a >> 2) % 1024);
      known = m_ram_ok[idx];
      return m_ram[idx];
    end
    if (a >= A_TX && a < A_TX + 16) begin
      case ((a - A_TX) / 4)
        0: return 32'd0;
        1: return {20'd0, 4'(cnt), 5'd0, m_ovf, cnt == 8, cnt == 0};
        2: return m_cyc;
        default: return m_exit;
      endcase
    end
    return 32'd0;
  endfunction

  function automatic void m_step(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
    bit          pop, push;
    logic [31:0] cyc_n;
    int          idx;
    pop   = (m_q.size() != 0) && rdy;
    push  = 0;
    cyc_n = m_halt ? m_cyc : m_cyc + 1;
    if (we && !m_halt) begin
      if (a < 32'h1000_0000) begin
        idx           = int'((a >> 2) % 1024);
        m_ram[idx]    = wd;
        m_ram_ok[idx] = 1;
      end else if (a >= A_TX && a < A_TX + 16) begin
        case ((a - A_TX) / 4)
          0: if (m_q.size() == 8) m_ovf = 1; else push = 1;
          1: if (wd[2]) m_ovf = 0;
          2: cyc_n = wd;
          default: begin m_halt = 1; m_exit = wd; end
        endcase
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(wd[7:0]);
    m_cyc = cyc_n;
  endfunction

  // One bus transaction: drive, check pre-edge view, clock, update model.
  task automatic do_cycle(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
    logic [31:0] exp;
    bit          known;
    bus.mem_write    = we;
    bus.data_addr_m  = a;
    bus.write_data_m = wd;
    tx_ready         = rdy;
    #1;
    exp = m_read(a, known);
    if (known) chk("read", bus.read_data_m, exp);
    chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
    chk("tx_data", 32'(tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    chk("halt", 32'(halt), 32'(m_halt));
    chk("exit_code", exit_code, m_exit);
    $display("txn t=%0t we=%0d addr=%h wd=%h rd=%h rdy=%0d txv=%0d txd=%h halt=%0d",
             $time, we, a, wd, bus.read_data_m, rdy, tx_valid, tx_data, halt);
    @(posedge clk);
    m_step(we, a, wd, rdy);
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.mem_write   = 1'b0;
    bus.data_addr_m = a;
    #1;
    chk(tag, bus.read_data_m, exp);
  endtask

  initial begin
    bit          we, rdy;
    logic [31:0] a, wd;

    bus.mem_write    = 1'b0;
    bus.data_addr_m  = 32'd0;
    bus.write_data_m = 32'd0;
    tx_ready         = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);

    peek("rst_cycle", A_CYC, 32'd0);
    peek("rst_status", A_ST, 32'h1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_exit", exit_code, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) do_cycle(0, A_CYC, 32'd0, 0);
    peek("cycle_at_10", A_CYC, 32'd10);

    // RAM write/read-back, alias, same-cycle old value
    do_cycle(1, 32'h0000_0100, 32'h1111_1111, 0);
    do_cycle(1, 32'h0000_0100, 32'hCAFE_F00D, 0);
    peek("ram_rd", 32'h0000_0100, 32'hCAFE_F00D);
    peek("ram_alias", 32'h0000_1100, 32'hCAFE_F00D);

    // Counter load and wrap
    do_cycle(1, A_CYC, 32'hFFFF_FFFE, 0);
    peek("cyc_load", A_CYC, 32'hFFFF_FFFE);
    do_cycle(0, A_CYC, 32'd0, 0);
    peek("cyc_ffff", A_CYC, 32'hFFFF_FFFF);
    do_cycle(0, A_CYC, 32'd0, 0);
    peek("cyc_wrap", A_CYC, 32'd0);

    // Fill and overflow
    for (int i = 0; i < 9; i++) do_cycle(1, A_TX, 32'h41 + 32'(i), 0);
    peek("status_ovf", A_ST, 32'h0000_0806);
    for (int i = 0; i < 8; i++) begin
      chk("drain_byte", 32'(tx_data), 32'h41 + 32'(i));
      do_cycle(0, A_ST, 32'd0, 1);
    end
    chk("drained_valid", 32'(tx_valid), 32'd0);
    do_cycle(1, A_ST, 32'h4, 0);
    peek("ovf_clr", A_ST, 32'h1);

    // Simultaneous push and pop
    for (int i = 0; i < 3; i++) do_cycle(1, A_TX, 32'h30 + 32'(i), 0);
    for (int i = 0; i < 5; i++) do_cycle(1, A_TX, 32'h5A, 1);
    peek("pp_count", A_ST, 32'h0000_0300);
    for (int i = 0; i < 4; i++) do_cycle(0, A_ST, 32'd0, 1);

    // Randomized traffic (no tohost writes)
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      case ($urandom_range(0, 5))
        0, 1: a = ($urandom & 32'h0FFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
        2, 3: a = A_TX | (32'($urandom_range(0, 2)) << 2) | 32'($urandom_range(0, 3));
        4: begin a = A_TH; we = 0; end
        default: a = ($urandom_range(0, 1) == 0) ? {4'($urandom_range(2, 15)), 28'($urandom)}
                                                 : A_TX + 32'h10 + (32'($urandom_range(0, 255)) << 4);
      endcase
      rdy = ($urandom_range(0, 3) == 0);
      do_cycle(we, a, wd, rdy);
    end

    // Async reset with bytes queued
    for (int i = 0; i < 10; i++) do_cycle(0, A_ST, 32'd0, 1);
    do_cycle(1, A_TX, 32'h61, 0);
    do_cycle(1, A_TX, 32'h62, 0);
    chk("pre_rst_valid", 32'(tx_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_tx_valid", 32'(tx_valid), 32'd0);
    peek("arst_cycle", A_CYC, 32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;

    // Halt
    do_cycle(1, A_TX, 32'h71, 0);
    do_cycle(1, A_TX, 32'h72, 0);
    do_cycle(1, 32'h0000_0100, 32'hA5A5_A5A5, 0);
    do_cycle(1, A_TH, 32'h1, 0);
    chk("halt_set", 32'(halt), 32'd1);
    chk("exit_set", exit_code, 32'h1);
    do_cycle(1, 32'h0000_0100, 32'hDEAD_BEEF, 0);
    peek("halt_ram", 32'h0000_0100, 32'hA5A5_A5A5);
    peek("halt_cyc0", A_CYC, m_cyc);
    do_cycle(1, A_CYC, 32'h1234, 0);
    do_cycle(1, A_TX, 32'h77, 0);
    do_cycle(1, A_TH, 32'h99, 0);
    peek("halt_cyc1", A_CYC, m_cyc);
    for (int i = 0; i < 3; i++) do_cycle(0, A_TH, 32'd0, 1);
    chk("halt_drained", 32'(tx_valid), 32'd0);

    #2 rst = 1'b0;
    #1;
    chk("arst_halt", 32'(halt), 32'd0);
    chk("arst_exit", exit_code, 32'd0);
    peek("arst_cycle2", A_CYC, 32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    peek("unmapped", 32'h2000_0000, 32'd0);
    peek("unmapped_mmio", 32'h1000_0010, 32'd0);
    do_cycle(1, 32'h2000_0000, 32'h5555_5555, 0);
    peek("unmapped_wr", 32'h2000_0000, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%h exp=%h", 32'd0, 32'd1);
    $fatal(1, "timeout");
  end

endmodule
